// File: rtl/sisc_ctrl_v2.sv
// sisc_ctrl_v2: multicycle SISC control FSM.
// Sequences START/FETCH/DECODE/EXECUTE/MEM/WRITEBACK, drives the datapath
// control lines, handshakes data memory via mem_req/mem_ack with an optional
// wait timeout, and parks in a resumable HALT state.
module sisc_ctrl_v2 #(
  parameter int CC_W        = 4,
  parameter int AM_IMM      = 8,
  parameter bit FAST_PATH   = 1'b0,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_f,
  input  logic [3:0]      opcode,
  input  logic [CC_W-1:0] mm,
  input  logic [CC_W-1:0] stat,
  input  logic            mem_ack,
  input  logic            resume,
  output logic            rf_we,
  output logic            rb_sel,
  output logic            pc_sel,
  output logic            pc_write,
  output logic            pc_rst,
  output logic            ir_load,
  output logic            br_sel,
  output logic            mux_16_sel,
  output logic            dm_we,
  output logic            mux4_swap_sel,
  output logic            swap_ctrl,
  output logic [1:0]      alu_op,
  output logic [1:0]      wb_sel,
  output logic            mem_req,
  output logic            halted,
  output logic            err,
  output logic            retire,
  output logic [2:0]      state
);

  localparam logic [2:0] S_START   = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_MEM     = 3'd4;
  localparam logic [2:0] S_WB      = 3'd5;
  localparam logic [2:0] S_HALT    = 3'd6;

  localparam logic [3:0] OP_LOD = 4'd1;
  localparam logic [3:0] OP_STR = 4'd2;
  localparam logic [3:0] OP_SWP = 4'd3;
  localparam logic [3:0] OP_BRA = 4'd4;
  localparam logic [3:0] OP_BRR = 4'd5;
  localparam logic [3:0] OP_BNE = 4'd6;
  localparam logic [3:0] OP_BNR = 4'd7;
  localparam logic [3:0] OP_ALU = 4'd8;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Counter must be able to hold MEM_TIMEOUT itself; keep at least one bit.
  localparam int               CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_V  = CNT_W'(MEM_TIMEOUT);
  localparam logic [CC_W-1:0]  AM_V  = CC_W'(AM_IMM);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             err_q, err_d;

  logic       is_lod, is_str, is_swp, is_mem, is_alu, is_hlt;
  logic       is_br_abs, is_skip, is_imm, cc_hit, br_taken, to_hit;
  logic [1:0] ex_alu_op;

  // Opcode classification and branch condition evaluation
  always_comb begin
    is_lod    = (opcode == OP_LOD);
    is_str    = (opcode == OP_STR);
    is_swp    = (opcode == OP_SWP);
    is_alu    = (opcode == OP_ALU);
    is_hlt    = (opcode == OP_HLT);
    is_mem    = is_lod || is_str || is_swp;
    is_br_abs = (opcode == OP_BRA) || (opcode == OP_BNE);
    // Branches and every undefined opcode (NOOP class) have no EXECUTE work.
    is_skip   = !is_mem && !is_alu && !is_hlt;
    is_imm    = (mm == AM_V);
    cc_hit    = |(stat & mm);
    br_taken  = 1'b0;
    if ((opcode == OP_BRA) || (opcode == OP_BRR)) br_taken = cc_hit;
    if ((opcode == OP_BNE) || (opcode == OP_BNR)) br_taken = !cc_hit;
    // MSB selects the non-ALU function class, LSB the immediate variant.
    ex_alu_op = {!is_alu, is_imm};
  end

  // Memory wait counter: zero outside MEM, counts unacknowledged request cycles
  always_comb begin
    cnt_inc = cnt_q + CNT_W'(1);
    // An ack in the same cycle always beats the timeout.
    to_hit  = (MEM_TIMEOUT > 0) && mem_req && !mem_ack && (cnt_inc == TO_V);
    cnt_d   = '0;
    if (state_q == S_MEM) cnt_d = (mem_req && !mem_ack) ? cnt_inc : cnt_q;
  end

  // Next-state and sticky error logic
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      S_START:   state_d = S_FETCH;
      S_FETCH:   state_d = S_DECODE;
      S_DECODE: begin
        if (is_hlt)                    state_d = S_HALT;
        else if (FAST_PATH && is_skip) state_d = S_FETCH;
        else                           state_d = S_EXECUTE;
      end
      S_EXECUTE: state_d = (FAST_PATH && is_alu) ? S_WB : S_MEM;
      S_MEM: begin
        if (!is_mem || mem_ack) state_d = S_WB;
        else if (to_hit) begin
          state_d = S_HALT;
          err_d   = 1'b1;
        end
      end
      S_WB:      state_d = S_FETCH;
      S_HALT:    if (resume) state_d = S_FETCH;
      default:   state_d = S_START;
    endcase
  end

  // Datapath control decode from registered state and live IR/status fields
  always_comb begin
    rf_we         = 1'b0;
    rb_sel        = 1'b0;
    pc_sel        = 1'b0;
    pc_write      = 1'b0;
    pc_rst        = 1'b0;
    ir_load       = 1'b0;
    br_sel        = 1'b0;
    mux_16_sel    = 1'b0;
    dm_we         = 1'b0;
    mux4_swap_sel = 1'b0;
    swap_ctrl     = 1'b0;
    alu_op        = 2'b00;
    wb_sel        = 2'b00;
    mem_req       = 1'b0;
    halted        = 1'b0;
    retire        = 1'b0;
    case (state_q)
      S_START: pc_rst = 1'b1;
      S_FETCH: begin
        pc_write = 1'b1;
        ir_load  = 1'b1;
      end
      S_DECODE: begin
        rb_sel = is_str || is_swp;
        if (br_taken) begin
          pc_sel   = 1'b1;
          pc_write = 1'b1;
          br_sel   = is_br_abs;
        end
        retire = FAST_PATH && is_skip;
      end
      S_EXECUTE: begin
        alu_op    = ex_alu_op;
        rb_sel    = is_str || is_swp;
        swap_ctrl = is_swp;
        if (is_lod) wb_sel = 2'd1;
        if (is_swp) wb_sel = 2'd2;
      end
      S_MEM: begin
        alu_op     = ex_alu_op;
        rb_sel     = is_str || is_swp;
        mem_req    = is_mem;
        mux_16_sel = (is_lod || is_str) && is_imm;
        // Write strobe only on the ack cycle so a store lands exactly once.
        dm_we      = is_str && mem_ack;
      end
      S_WB: begin
        rf_we         = is_alu || is_lod || is_swp;
        mux4_swap_sel = is_swp;
        if (is_lod) wb_sel = 2'd1;
        if (is_swp) wb_sel = 2'd3;
        retire        = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q <= S_START;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_sisc_ctrl_v2.sv
// tb_sisc_ctrl_v2: randomized instruction-level check of sisc_ctrl_v2.
// Two instances: index 0 without fast path, index 1 with fast path; both
// with a memory timeout of TO cycles. Expectations come from per-instruction
// latency/count rules, not from a cycle-level state model.
module tb_sisc_ctrl_v2;
  localparam int TO = 4;

  logic       clk;
  logic       rst_f [2];
  logic [3:0] opcode [2];
  logic [3:0] mm [2];
  logic [3:0] stat [2];
  logic       mem_ack [2];
  logic       resume [2];
  logic       rf_we [2], rb_sel [2], pc_sel [2], pc_write [2], pc_rst [2];
  logic       ir_load [2], br_sel [2], mux_16_sel [2], dm_we [2];
  logic       mux4_swap_sel [2], swap_ctrl [2];
  logic [1:0] alu_op [2], wb_sel [2];
  logic       mem_req [2], halted [2], err [2], retire [2];
  logic [2:0] state [2];

  int total = 0;
  int bad   = 0;
  logic err_exp [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sisc_ctrl_v2 #(.CC_W(4), .AM_IMM(8), .FAST_PATH(g == 1), .MEM_TIMEOUT(TO)) u_dut (
      .clk(clk), .rst_f(rst_f[g]), .opcode(opcode[g]), .mm(mm[g]), .stat(stat[g]),
      .mem_ack(mem_ack[g]), .resume(resume[g]),
      .rf_we(rf_we[g]), .rb_sel(rb_sel[g]), .pc_sel(pc_sel[g]), .pc_write(pc_write[g]),
      .pc_rst(pc_rst[g]), .ir_load(ir_load[g]), .br_sel(br_sel[g]),
      .mux_16_sel(mux_16_sel[g]), .dm_we(dm_we[g]), .mux4_swap_sel(mux4_swap_sel[g]),
      .swap_ctrl(swap_ctrl[g]), .alu_op(alu_op[g]), .wb_sel(wb_sel[g]),
      .mem_req(mem_req[g]), .halted(halted[g]), .err(err[g]), .retire(retire[g]),
      .state(state[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // All control outputs packed: bit13 = pc_rst, bit14 = pc_write, bit12 = ir_load, bit1 = halted.
  function automatic logic [17:0] ov(input int d);
    return {rf_we[d], rb_sel[d], pc_sel[d], pc_write[d], pc_rst[d], ir_load[d],
            br_sel[d], mux_16_sel[d], dm_we[d], mux4_swap_sel[d], swap_ctrl[d],
            alu_op[d], wb_sel[d], mem_req[d], halted[d], retire[d]};
  endfunction

  task automatic do_reset(input int d);
    @(negedge clk);
    rst_f[d] = 1'b1; resume[d] = 1'b0; mem_ack[d] = 1'b0; opcode[d] = 4'd0;
    repeat (2) @(negedge clk);
    rst_f[d] = 1'b0;
    #1;
    chk("rst_state", 32'(state[d]), 32'd0);
    chk("rst_outs", 32'(ov(d)), 32'h02000);
    chk("rst_err", 32'(err[d]), 32'd0);
    @(negedge clk); #1;
    chk("rst_fetch_state", 32'(state[d]), 32'd1);
    chk("rst_fetch_outs", 32'(ov(d)), 32'h05000);
    err_exp[d] = 1'b0;
  endtask

  // Runs one instruction from FETCH; n = request cycle on which mem_ack arrives.
  task automatic run_instr(input int d, input logic [3:0] op, input logic [3:0] m,
                           input logic [3:0] s, input int n);
    bit fast, hlt, lod, str, swp, alu, memop, skip, taken, tmo, ended, hl, alu_bad;
    int exp_lat, exp_req, exp_alu, exp_wb, c, nreq, nwe, nret, lat, k;
    logic dpw, dps, dbr, drb, rrf, rm4, m16;
    logic [1:0] exa, rwb;
    fast  = (d == 1);
    hlt   = (op == 4'd15);
    lod   = (op == 4'd1);
    str   = (op == 4'd2);
    swp   = (op == 4'd3);
    alu   = (op == 4'd8);
    memop = lod || str || swp;
    skip  = fast && !memop && !alu && !hlt;
    taken = (((op == 4'd4) || (op == 4'd5)) && ((s & m) != 4'd0)) ||
            (((op == 4'd6) || (op == 4'd7)) && ((s & m) == 4'd0));
    tmo   = memop && (n > TO);
    if (hlt)             exp_lat = 3;
    else if (skip)       exp_lat = 2;
    else if (tmo)        exp_lat = 4 + TO;
    else if (fast && alu) exp_lat = 4;
    else                 exp_lat = 4 + (memop ? n : 1);
    exp_req = memop ? (tmo ? TO : n) : 0;
    exp_alu = (m == 4'd8) ? (alu ? 1 : 3) : (alu ? 0 : 2);
    exp_wb  = skip ? 0 : (lod ? 1 : (swp ? 3 : 0));

    opcode[d] = op; mm[d] = m; stat[d] = s; resume[d] = 1'b0; mem_ack[d] = 1'b0;
    #1;
    chk("fetch_state", 32'(state[d]), 32'd1);
    c = 0; nreq = 0; nwe = 0; nret = 0; lat = 0; ended = 0; hl = 0; alu_bad = 0;
    dpw = 0; dps = 0; dbr = 0; drb = 0; rrf = 0; rm4 = 0; m16 = 0; exa = 0; rwb = 0;
    while (!ended && c < 40) begin
      c++;
      if (mem_req[d]) begin
        nreq++;
        mem_ack[d] = (nreq == n);
      end else begin
        mem_ack[d] = 1'($urandom_range(0, 1));
      end
      #1;
      if (c == 2) begin dpw = pc_write[d]; dps = pc_sel[d]; dbr = br_sel[d]; drb = rb_sel[d]; end
      if (c == 3) exa = alu_op[d];
      if (mem_req[d]) begin
        if (alu_op[d] != 2'(exp_alu)) alu_bad = 1;
        if (nreq == 1) m16 = mux_16_sel[d];
      end
      if (dm_we[d]) nwe++;
      if (retire[d]) begin
        nret++; ended = 1; lat = c; rwb = wb_sel[d]; rrf = rf_we[d]; rm4 = mux4_swap_sel[d];
      end
      if (halted[d]) begin
        hl = 1; ended = 1; lat = c;
        chk("halt_outs", 32'(ov(d)), 32'h00002);
      end
      if (!ended) @(negedge clk);
    end
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("retired", 32'(nret), (hlt || tmo) ? 32'd0 : 32'd1);
    chk("halted", 32'(hl), 32'(hlt || tmo));
    chk("mem_req_cycles", 32'(nreq), 32'(exp_req));
    chk("dm_we_cycles", 32'(nwe), (str && !tmo) ? 32'd1 : 32'd0);
    chk("dec_pc_write", 32'(dpw), 32'(taken));
    chk("dec_pc_sel", 32'(dps), 32'(taken));
    chk("dec_br_sel", 32'(dbr), 32'(taken && ((op == 4'd4) || (op == 4'd6))));
    chk("dec_rb_sel", 32'(drb), 32'(str || swp));
    if (!hlt && !skip) chk("ex_alu_op", 32'(exa), 32'(exp_alu));
    if (memop) begin
      chk("mem_alu_hold", 32'(alu_bad), 32'd0);
      chk("mem_mux16", 32'(m16), 32'((lod || str) && (m == 4'd8)));
    end
    if (nret == 1) begin
      chk("wb_sel", 32'(rwb), 32'(exp_wb));
      chk("rf_we", 32'(rrf), 32'(!skip && (alu || lod || swp)));
      chk("mux4_swap", 32'(rm4), 32'(!skip && swp));
    end
    if (tmo) err_exp[d] = 1'b1;
    mem_ack[d] = 1'b0;
    if (hl) begin
      k = $urandom_range(0, 2);
      repeat (k) begin
        @(negedge clk); #1;
        chk("halt_hold", 32'(halted[d]), 32'd1);
      end
      resume[d] = 1'b1;
      @(negedge clk);
      resume[d] = 1'b0;
    end else begin
      @(negedge clk);
    end
    #1;
    chk("err_flag", 32'(err[d]), 32'(err_exp[d]));
  endtask

  // Reset asserted while a store waits for its ack.
  task automatic mem_reset_test(input int d);
    int k;
    opcode[d] = 4'd2; mm[d] = 4'd0; mem_ack[d] = 1'b0; resume[d] = 1'b0;
    k = 0;
    while (!mem_req[d] && k < 10) begin @(negedge clk); #1; k++; end
    chk("reach_mem", 32'(mem_req[d]), 32'd1);
    @(negedge clk); #1;
    chk("err_before_rst", 32'(err[d]), 32'(err_exp[d]));
    rst_f[d] = 1'b1;
    @(negedge clk); #1;
    chk("mrst_state", 32'(state[d]), 32'd0);
    chk("mrst_req", 32'(mem_req[d]), 32'd0);
    chk("mrst_err", 32'(err[d]), 32'd0);
    rst_f[d] = 1'b0;
    err_exp[d] = 1'b0;
    @(negedge clk); #1;
    chk("mrst_fetch", 32'(state[d]), 32'd1);
  endtask

  // Reset and resume together while halted: reset must win.
  task automatic halt_reset_test(input int d);
    int k;
    opcode[d] = 4'd15; mem_ack[d] = 1'b0; resume[d] = 1'b0;
    k = 0;
    while (!halted[d] && k < 10) begin @(negedge clk); #1; k++; end
    chk("hrst_halted", 32'(halted[d]), 32'd1);
    rst_f[d] = 1'b1; resume[d] = 1'b1;
    @(negedge clk); #1;
    chk("hrst_state", 32'(state[d]), 32'd0);
    rst_f[d] = 1'b0; resume[d] = 1'b0;
    @(negedge clk); #1;
    chk("hrst_fetch", 32'(state[d]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_f[i] = 1'b1; opcode[i] = 4'd0; mm[i] = 4'd0; stat[i] = 4'd0;
      mem_ack[i] = 1'b0; resume[i] = 1'b0; err_exp[i] = 1'b0;
    end
    for (int d = 0; d < 2; d++) begin
      do_reset(d);
      run_instr(d, 4'd8, 4'd8, 4'd0, 1);               // ALU immediate
      run_instr(d, 4'd2, 4'd0, 4'd0, 3);               // STR, ack on 3rd request cycle
      run_instr(d, 4'd4, 4'b0010, 4'b0010, 1);         // BRA taken
      run_instr(d, 4'd7, 4'b0010, 4'b0010, 1);         // BNR not taken
      run_instr(d, 4'd7, 4'b0100, 4'b0010, 1);         // BNR taken
      run_instr(d, 4'd1, 4'd0, 4'd0, 99);              // LOD timeout
      run_instr(d, 4'd1, 4'd8, 4'd0, TO);              // ack on the timeout cycle
      run_instr(d, 4'd3, 4'd8, 4'd0, 2);               // SWP
      run_instr(d, 4'd15, 4'd0, 4'd0, 1);              // HLT
      for (int i = 0; i < 60; i++) begin
        logic [3:0] op, m, s;
        int n;
        op = 4'($urandom_range(0, 15));
        m  = ($urandom_range(0, 3) == 0) ? 4'd8 : 4'($urandom);
        s  = 4'($urandom);
        n  = $urandom_range(1, 5);
        run_instr(d, op, m, s, n);
      end
      mem_reset_test(d);
      halt_reset_test(d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sisc_ctrl_v2.md
# sisc_ctrl_v2

Second-generation SISC control unit: a synthesizable multicycle FSM that sequences fetch/decode/execute/mem/writeback and drives the datapath control lines. Against the first-generation controller it adds:

- a parametrised condition-code width;
- a `mem_req`/`mem_ack` data-memory handshake with an optional timeout;
- an optional fast path that skips unused states;
- a resumable HALT state instead of a simulator stop.

It sits between the IR/status register and the datapath muxes, register file, PC and data memory.

## Interface
Parameters:
- CC_W, 4, width of `mm` (IR condition/mode field) and `stat` (status flags)
- AM_IMM, 8, `mm` value selecting immediate addressing
- FAST_PATH, 0, 1 = non-memory instructions skip unused states
- MEM_TIMEOUT, 0, max cycles waiting for `mem_ack`; 0 = wait forever

Ports (clock and reset first):
- clk  in  1  system clock, all state changes on rising edge
- rst_f  in  1  reset; one clock; reset is synchronous and active-high (rst_f=1 at a rising edge resets)
- opcode  in  4  IR opcode: NOOP=0, LOD=1, STR=2, SWP=3, BRA=4, BRR=5, BNE=6, BNR=7, ALU_OP=8, HLT=15; others treated as NOOP
- mm  in  CC_W  condition mask / addressing mode
- stat  in  CC_W  status flags
- mem_ack  in  1  data memory completed request this cycle
- resume  in  1  leave HALT
- rf_we, rb_sel, pc_sel, pc_write, pc_rst, ir_load, br_sel, mux_16_sel, dm_we, mux4_swap_sel, swap_ctrl  out  1 each  datapath controls
- alu_op, wb_sel  out  2 each  ALU function / writeback source
- mem_req  out  1  data memory request
- halted  out  1  in HALT
- err  out  1  sticky memory-timeout flag
- retire  out  1  one-cycle pulse per completed instruction
- state  out  3  START=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WRITEBACK=5, HALT=6

## Operation
**Output decode**
- Outputs are combinational from registered state plus opcode/mm/stat.
- Every output not listed for a state is 0.

**Per-state outputs**
- START: pc_rst=1. Next state FETCH, unconditionally.
- FETCH: pc_write=1, ir_load=1. Next state DECODE.
- DECODE:
  - rb_sel=1 for STR/SWP.
  - Branch taken when BRA/BRR and (stat&mm)!=0, or BNE/BNR and (stat&mm)==0.
  - On a taken branch: pc_sel=1, pc_write=1; br_sel=1 for BRA/BNE (absolute), 0 for BRR/BNR (relative).
  - HLT goes to HALT.
  - With FAST_PATH=1, branches and NOOP go to FETCH with retire=1. All other cases go to EXECUTE.
- EXECUTE:
  - alu_op: ALU_OP → 01 if mm==AM_IMM, else 00. All other opcodes → 11 if mm==AM_IMM, else 10.
  - wb_sel: 1 for LOD, 2 for SWP. swap_ctrl=1 for SWP. rb_sel=1 for STR/SWP.
  - Next state: MEM for LOD/STR/SWP. With FAST_PATH=1, ALU_OP goes to WRITEBACK. With FAST_PATH=0, everything goes to MEM.
- MEM:
  - EXECUTE alu_op/rb_sel are held.
  - For LOD/STR/SWP: mem_req=1. For LOD/STR: mux_16_sel=(mm==AM_IMM). dm_we=1 only for STR in the cycle mem_ack=1, giving exactly one write.
  - Stay in MEM until mem_ack=1. Non-memory opcodes leave MEM after one cycle without mem_req.
  - Next state WRITEBACK.
- WRITEBACK:
  - rf_we=1 for ALU_OP/LOD/SWP.
  - wb_sel: 0 for ALU_OP, 1 for LOD, 3 for SWP. mux4_swap_sel=1 for SWP.
  - retire=1. Next state FETCH.
- HALT: halted=1, no other outputs. resume=1 goes to FETCH; otherwise stay.

**Memory timeout**
- Wait counter clears on MEM entry and increments each MEM cycle with mem_req=1 and mem_ack=0.
- When MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with mem_ack=0: go to HALT and set err=1.
- Counter width is clog2(MEM_TIMEOUT+1), minimum 1.
- err clears only on reset.

## Timing
**Reset**
- rst_f=1 at a rising edge forces state=START from any state, including mid-MEM-wait or HALT.
- Reset also clears the wait counter and err.
- While in START: pc_rst=1; all other outputs 0 (alu_op=00, wb_sel=00).

**Latency (from FETCH to retire)**
- FAST_PATH=0: every non-HLT instruction takes 5 cycles plus extra mem_ack wait cycles.
- FAST_PATH=1:
  - branch/NOOP: 2 cycles (retire in DECODE)
  - ALU_OP: 4 cycles
  - LOD/STR/SWP: 5 cycles plus extra mem_ack wait cycles

**Boundary rules**
- mem_ack is honoured only in MEM while mem_req=1; it is ignored elsewhere.
- mem_ack=1 in the same cycle the counter hits MEM_TIMEOUT: ack wins, no error.
- resume and rst_f both high: reset wins.
- HLT is never retired.

## Test plan
- Reset sequence: rst_f=1 for 2 cycles, then 0 → state 0 with pc_rst=1, next cycle FETCH with pc_write=1 and ir_load=1.
- ALU_OP, mm=8, FAST_PATH=1 → EXECUTE alu_op=01, WRITEBACK rf_we=1 and wb_sel=0, retire 4 cycles after FETCH. Same with FAST_PATH=0 → retire at 5.
- STR, mm=0, mem_ack delayed 3 cycles → mem_req high for 3 cycles, dm_we high exactly 1 cycle (the ack cycle), alu_op=10 throughout.
- Branches, stat=4'b0010:
  - BRA mm=4'b0010 → DECODE pc_sel=1, pc_write=1, br_sel=1.
  - BNR mm=4'b0010 → not taken, pc_write=0.
  - BNR mm=4'b0100 → taken, br_sel=0.
- MEM_TIMEOUT=4, LOD with no mem_ack → HALT after 4 MEM cycles, err=1, halted=1. resume → FETCH, err stays 1. Reset → err=0.
- HLT in DECODE → HALT, no retire. Assert rst_f during a MEM wait → START next cycle, mem_req=0.
